// File: rtl/module_sumador_secuencial.sv
// Wide adder that reuses one ANCHO-bit ripple-carry slice over N_SLICES cycles.
// Optional macro OVERFLOW_EN adds ov_o, the signed overflow of the top slice.

module module_sumador_secuencial_slice #(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             ci,
`ifdef OVERFLOW_EN
  output logic             ov,
`endif
  output logic [ANCHO-1:0] s,
  output logic             co
);

  logic [ANCHO:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < ANCHO; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[ANCHO];
`ifdef OVERFLOW_EN
  // Carry into the MSB differs from carry out of it exactly on signed overflow.
  assign ov = c[ANCHO] ^ c[ANCHO-1];
`endif

endmodule

// Handshake: an operand transfer happens on a rising edge where valid_i && ready_o;
// a result transfer happens on a rising edge where valid_o && ready_i. Once raised,
// valid_o and the result stay put until the transfer completes.
module module_sumador_secuencial #(
  parameter int ANCHO    = 8,
  parameter int N_SLICES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [ANCHO*N_SLICES-1:0]   a_i,
  input  logic [ANCHO*N_SLICES-1:0]   b_i,
  input  logic                        ci_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [ANCHO*N_SLICES-1:0]   s_o,
  output logic                        co_o,
`ifdef OVERFLOW_EN
  output logic                        ov_o,
`endif
  output logic [1:0]                  state_dbg
);

  localparam int W     = ANCHO * N_SLICES;
  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_reg, b_reg, s_reg;
  logic [IDX_W-1:0] idx;
  logic             carry, co_reg;
  logic [ANCHO-1:0] op_a, op_b, slice_s;
  logic             slice_co;
`ifdef OVERFLOW_EN
  logic             slice_ov, ov_reg;
`endif

  // Select the operand slices addressed by idx for the shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < N_SLICES; k++) begin
      if (idx == IDX_W'(k)) begin
        op_a = a_reg[k*ANCHO +: ANCHO];
        op_b = b_reg[k*ANCHO +: ANCHO];
      end
    end
  end

  module_sumador_secuencial_slice #(
    .ANCHO (ANCHO)
  ) u_slice (
    .a  (op_a),
    .b  (op_b),
    .ci (carry),
`ifdef OVERFLOW_EN
    .ov (slice_ov),
`endif
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = SUMA;
      SUMA:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      s_reg  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      co_reg <= 1'b0;
`ifdef OVERFLOW_EN
      ov_reg <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_reg <= a_i;
            b_reg <= b_i;
            carry <= ci_i;
            idx   <= '0;
          end
        end
        SUMA: begin
          for (int k = 0; k < N_SLICES; k++) begin
            if (idx == IDX_W'(k)) s_reg[k*ANCHO +: ANCHO] <= slice_s;
          end
          carry <= slice_co;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            co_reg <= slice_co;
`ifdef OVERFLOW_EN
            ov_reg <= slice_ov;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags come straight from the state register.
  assign ready_o   = (state == IDLE);
  assign valid_o   = (state == DONE);
  assign s_o       = s_reg;
  assign co_o      = co_reg;
  assign state_dbg = state;
`ifdef OVERFLOW_EN
  assign ov_o      = ov_reg;
`endif

endmodule

// File: tb/tb_module_sumador_secuencial.sv
// Scoreboard bench for module_sumador_secuencial: random operands, arithmetic reference model.
module tb_module_sumador_secuencial;

  localparam int ANCHO    = 8;
  localparam int N_SLICES = 4;
  localparam int W        = ANCHO * N_SLICES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i, b_i;
  logic         ci_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] s_o;
  logic         co_o;
  logic [1:0]   state_dbg;
`ifdef OVERFLOW_EN
  logic         ov_o;
`endif

  module_sumador_secuencial #(
    .ANCHO    (ANCHO),
    .N_SLICES (N_SLICES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .ci_i      (ci_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .s_o       (s_o),
    .co_o      (co_o),
`ifdef OVERFLOW_EN
    .ov_o      (ov_o),
`endif
    .state_dbg (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int ncyc = 0;
  always @(posedge clk) ncyc++;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 0;

  // expected entry layout: {ov, co, s}
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference model: plain wide arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ov, full[W], s};
  endfunction

  // driver: called just after a rising edge; returns just after the accept edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input bit keep_valid, output int acc_cyc);
    int guard = 0;
    a_i = a; b_i = b; ci_i = ci; valid_i = 1'b1;
    acc_cyc = -1;
    @(negedge clk);
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      check("accept_timeout", {63'd0, ready_o}, 64'd1);
    end else begin
      exp_q.push_back(model(a, b, ci));
      acc_cyc = ncyc;
    end
    @(posedge clk);
    #1;
    if (!keep_valid) valid_i = 1'b0;
    a_i  = $urandom;
    b_i  = $urandom;
    ci_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
    check({tag, "_sum"},   64'(s_o), 64'd0);
    check({tag, "_co"},    {63'd0, co_o}, 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'd0);
`ifdef OVERFLOW_EN
    check({tag, "_ov"},    {63'd0, ov_o}, 64'd0);
`endif
  endtask

  // monitor: latency, busy flag, hold stability and result comparison
  bit           pend = 0, seen_v = 0, held = 0, after_xfer = 0;
  int           since = 0;
  logic [W-1:0] held_s;
  logic         held_co;

  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst_n) begin
      pend = 0; seen_v = 0; held = 0; after_xfer = 0;
    end else begin
      if (after_xfer) begin
        check("post_xfer_ready", {63'd0, ready_o}, 64'd1);
        check("post_xfer_valid", {63'd0, valid_o}, 64'd0);
        after_xfer = 0;
      end
      if (pend) begin
        since++;
        check("busy_ready", {63'd0, ready_o}, 64'd0);
        if (valid_o && !seen_v) begin
          check("latency", 64'(since), 64'(N_SLICES + 1));
          seen_v = 1;
        end
      end
      if (held) check("valid_hold", {63'd0, valid_o}, 64'd1);
      if (valid_o) begin
        if (held) begin
          check("hold_sum", 64'(s_o), 64'(held_s));
          check("hold_co",  {63'd0, co_o}, {63'd0, held_co});
        end
        check("result_expected", 64'(exp_q.size()), 64'd1);
        if (ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sum",       64'(s_o), 64'(e[W-1:0]));
          check("carry_out", {63'd0, co_o}, {63'd0, e[W]});
`ifdef OVERFLOW_EN
          check("overflow",  {63'd0, ov_o}, {63'd0, e[W+1]});
`endif
          pend = 0; seen_v = 0; held = 0; after_xfer = 1;
        end else begin
          held = 1; held_s = s_o; held_co = co_o;
        end
      end
      if (valid_i && ready_o) begin
        pend = 1; since = 0; seen_v = 0;
      end
    end
  end

  // optional random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int acc1, acc2, g;
    rst_n = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0; ci_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // carry ripples through every slice
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, acc1);
    drain();

    // carry-in used; operands scrambled during SUMA by the driver
    issue(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 0, acc1);
    drain();

    // backpressure with ignored valid_i pulses
    ready_i = 1'b0;
    issue($urandom, $urandom, 1'b1, 0, acc1);
    g = 0;
    while (!valid_o && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("bp_valid_seen", {63'd0, valid_o}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      valid_i = 1'($urandom_range(0, 1));
      a_i = $urandom;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    drain();

    // reset mid-operation, sampled two edges after accept
    issue(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 0, acc1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("midop_reset");
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // back-to-back with valid_i held high
    issue($urandom, $urandom, 1'b0, 1, acc1);
    issue($urandom, $urandom, 1'b1, 0, acc2);
    check("issue_interval", 64'(acc2 - acc1), 64'(N_SLICES + 2));
    drain();

`ifdef OVERFLOW_EN
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, acc1);
    drain();
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, acc1);
    drain();
`endif

    // random traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 25; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 0, acc1);
      drain();
    end
    rand_ready = 0;
    #2 ready_i = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
